// File: rtl/store_pkg.sv
// Shared definitions for the store unit: funct3 store widths, FSM states and
// the width-to-byte-mask helper.
package store_pkg;

  localparam logic [2:0] FUNCT3_SB = 3'd0;
  localparam logic [2:0] FUNCT3_SH = 3'd1;
  localparam logic [2:0] FUNCT3_SW = 3'd2;
  localparam logic [2:0] FUNCT3_SD = 3'd3;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite
  } store_state_e;

  // Unshifted byte mask for a store width encoded as funct3[1:0].
  function automatic logic [7:0] width_byte_mask(input logic [1:0] width);
    logic [7:0] mask;
    unique case (width)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/store_if.sv
// Store request and data-memory port bundle. The unit side uses the slave
// modport; the execute stage and memory side use master.
interface store_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                    store_valid;
  logic                    store_ready;
  logic [2:0]              funct3;
  logic [XLEN-1:0]         rs1_value;
  logic [XLEN-1:0]         rs2_value;
  logic [11:0]             immediate12_store;
  logic                    memory_read_request;
  logic [ADDR_WIDTH-1:0]   memory_read_address;
  logic                    memory_read_valid;
  logic [XLEN-1:0]         memory_read_value;
  logic                    memory_write_request;
  logic [ADDR_WIDTH-1:0]   memory_write_address;
  logic [XLEN-1:0]         memory_write_value;
  logic [XLEN/8-1:0]       memory_write_strobe;
  logic                    memory_write_ack;
  logic                    store_done;
  logic                    store_fault;

  modport slave (
    input  store_valid, funct3, rs1_value, rs2_value, immediate12_store,
           memory_read_valid, memory_read_value, memory_write_ack,
    output store_ready, memory_read_request, memory_read_address,
           memory_write_request, memory_write_address, memory_write_value,
           memory_write_strobe, store_done, store_fault
  );

  modport master (
    output store_valid, funct3, rs1_value, rs2_value, immediate12_store,
           memory_read_valid, memory_read_value, memory_write_ack,
    input  store_ready, memory_read_request, memory_read_address,
           memory_write_request, memory_write_address, memory_write_value,
           memory_write_strobe, store_done, store_fault
  );

endinterface

// File: rtl/store_lane_merge.sv
// Byte-lane merge of store data into a memory word (RMW), or shifted data plus
// byte strobes when STORE_BYTE_ENABLE_EN is defined.
module store_lane_merge
  import store_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]                width,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [XLEN-1:0]           store_data,
  input  logic [XLEN-1:0]           read_word,
  output logic [XLEN-1:0]           value,
  output logic [XLEN/8-1:0]         strobe
);

  localparam int unsigned NumBytes = XLEN / 8;

  logic [7:0]          base_mask;
  logic                unused_base_mask;
  logic [NumBytes-1:0] byte_mask;
  logic [XLEN-1:0]     shifted;

  assign base_mask        = width_byte_mask(width);
  assign unused_base_mask = ^base_mask;
  assign byte_mask        = base_mask[NumBytes-1:0] << offset;
  assign shifted          = store_data << {offset, 3'b000};

`ifdef STORE_BYTE_ENABLE_EN
  logic unused_read_word;
  assign unused_read_word = ^read_word;
  assign value            = shifted;
  assign strobe           = byte_mask;
`else
  logic [XLEN-1:0] bit_mask;

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < int'(NumBytes); i++) begin
      bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    end
  end

  // The merged word is complete, so every lane is written.
  assign value  = (read_word & ~bit_mask) | (shifted & bit_mask);
  assign strobe = '1;
`endif

endmodule

// File: rtl/store_unit.sv
// RISC-V store unit: address generation, width/alignment checks and RMW or
// strobed writes. Define STORE_BYTE_ENABLE_EN to skip the read phase.
module store_unit
  import store_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic   clock,
  input  logic   reset_n,
  store_if.slave bus
);

  localparam int unsigned NumBytes  = XLEN / 8;
  localparam int unsigned OffWidth  = $clog2(NumBytes);
  localparam bit          HasSd     = (XLEN == 64);
  localparam logic [1:0]  FullWidth = HasSd ? 2'd3 : 2'd2;

  store_state_e          state_q, state_d;
  logic [1:0]            width_q, width_d;
  logic [OffWidth-1:0]   off_q, off_d;
  logic [XLEN-1:0]       rs2_q, rs2_d;
  logic                  rd_req_q, rd_req_d;
  logic                  wr_req_q, wr_req_d;
  logic                  done_q, done_d;
  logic                  fault_q, fault_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       wr_value_q, wr_value_d;
  logic [NumBytes-1:0]   wr_strobe_q, wr_strobe_d;

  logic [ADDR_WIDTH-1:0] ea, aligned;
  logic [OffWidth-1:0]   off_in;
  logic                  illegal, misaligned, partial, in_read;
  logic [1:0]            merge_width;
  logic [OffWidth-1:0]   merge_offset;
  logic [XLEN-1:0]       merge_data, merge_read, merge_value;
  logic [NumBytes-1:0]   merge_strobe;

  assign ea      = bus.rs1_value[ADDR_WIDTH-1:0]
                 + {{(ADDR_WIDTH - 12){bus.immediate12_store[11]}}, bus.immediate12_store};
  assign off_in  = ea[OffWidth-1:0];
  assign aligned = {ea[ADDR_WIDTH-1:OffWidth], {OffWidth{1'b0}}};
  assign illegal = bus.funct3[2] || (!HasSd && (bus.funct3 == FUNCT3_SD));

  always_comb begin
    misaligned = 1'b0;
    case (bus.funct3)
      FUNCT3_SH: misaligned = off_in[0];
      FUNCT3_SW: misaligned = |off_in[1:0];
      FUNCT3_SD: misaligned = |off_in;
      default:   misaligned = 1'b0;
    endcase
  end

`ifdef STORE_BYTE_ENABLE_EN
  assign partial = 1'b0;
`else
  assign partial = (bus.funct3[1:0] != FullWidth);
`endif

  // One merge instance: fed by live operands at accept, latched ones in READ.
  assign in_read      = (state_q == StRead);
  assign merge_width  = in_read ? width_q : bus.funct3[1:0];
  assign merge_offset = in_read ? off_q : off_in;
  assign merge_data   = in_read ? rs2_q : bus.rs2_value;
  assign merge_read   = in_read ? bus.memory_read_value : '0;

  store_lane_merge #(
    .XLEN (XLEN)
  ) u_lane_merge (
    .width      (merge_width),
    .offset     (merge_offset),
    .store_data (merge_data),
    .read_word  (merge_read),
    .value      (merge_value),
    .strobe     (merge_strobe)
  );

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    off_d       = off_q;
    rs2_d       = rs2_q;
    rd_req_d    = rd_req_q;
    wr_req_d    = wr_req_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_value_d  = wr_value_q;
    wr_strobe_d = wr_strobe_q;
    unique case (state_q)
      StIdle: begin
        if (bus.store_valid) begin
          if (illegal || misaligned) begin
            fault_d = 1'b1;
          end else begin
            width_d   = bus.funct3[1:0];
            off_d     = off_in;
            rs2_d     = bus.rs2_value;
            rd_addr_d = aligned;
            wr_addr_d = aligned;
            if (partial) begin
              rd_req_d = 1'b1;
              state_d  = StRead;
            end else begin
              wr_req_d    = 1'b1;
              wr_value_d  = merge_value;
              wr_strobe_d = merge_strobe;
              state_d     = StWrite;
            end
          end
        end
      end
      StRead: begin
        if (bus.memory_read_valid) begin
          rd_req_d    = 1'b0;
          wr_req_d    = 1'b1;
          wr_value_d  = merge_value;
          wr_strobe_d = merge_strobe;
          state_d     = StWrite;
        end
      end
      StWrite: begin
        if (bus.memory_write_ack) begin
          wr_req_d = 1'b0;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      width_q     <= '0;
      off_q       <= '0;
      rs2_q       <= '0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_value_q  <= '0;
      wr_strobe_q <= '0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      off_q       <= off_d;
      rs2_q       <= rs2_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_value_q  <= wr_value_d;
      wr_strobe_q <= wr_strobe_d;
    end
  end

  assign bus.store_ready          = (state_q == StIdle);
`ifdef STORE_BYTE_ENABLE_EN
  logic unused_rd_req;
  assign unused_rd_req            = rd_req_q;
  assign bus.memory_read_request  = 1'b0;
`else
  assign bus.memory_read_request  = rd_req_q;
`endif
  assign bus.memory_read_address  = rd_addr_q;
  assign bus.memory_write_request = wr_req_q;
  assign bus.memory_write_address = wr_addr_q;
  assign bus.memory_write_value   = wr_value_q;
  assign bus.memory_write_strobe  = wr_strobe_q;
  assign bus.store_done           = done_q;
  assign bus.store_fault          = fault_q;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit (XLEN=32) against a byte-level reference
// model; adapts its expectations when STORE_BYTE_ENABLE_EN is defined.
module tb_store_unit;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ADDR_WIDTH = 32;
`ifdef STORE_BYTE_ENABLE_EN
  localparam bit ByteEn = 1'b1;
`else
  localparam bit ByteEn = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   n_cmp   = 0;
  int   n_err   = 0;

  store_if #(.XLEN(XLEN), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  store_unit #(.XLEN(XLEN), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one store, plays memory with the given wait cycles and checks every
  // observable against the reference model. Returns the observed write word.
  task automatic run_store(input logic [2:0] f3, input logic [31:0] rs1, input logic [11:0] imm,
                           input logic [31:0] rs2, input logic [31:0] rword,
                           input int rd_dly, input int ack_dly,
                           output logic [31:0] obs_value, output logic [3:0] obs_strobe);
    logic [31:0] ea, exp_addr, exp_value;
    logic [3:0]  exp_strobe;
    int          nbytes, off, cyc, rd_wait, ack_wait, exp_lat;
    bit          fault, need_read, saw_read, saw_write, done, in_lane;
    ea       = rs1 + {{20{imm[11]}}, imm};
    off      = int'(ea % 32'd4);
    exp_addr = ea - 32'(off);
    case (f3)
      3'd0:    nbytes = 1;
      3'd1:    nbytes = 2;
      3'd2:    nbytes = 4;
      default: nbytes = 0;
    endcase
    if (nbytes == 0) fault = 1'b1;
    else             fault = (off % nbytes) != 0;
    need_read = !fault && !ByteEn && (nbytes < 4);
    for (int b = 0; b < 4; b++) begin
      in_lane = (b >= off) && (b < off + nbytes);
      if (in_lane)     exp_value[8*b +: 8] = 8'(rs2 >> (8 * (b - off)));
      else if (ByteEn) exp_value[8*b +: 8] = 8'h00;
      else             exp_value[8*b +: 8] = rword[8*b +: 8];
      exp_strobe[b] = ByteEn ? in_lane : 1'b1;
    end
    exp_lat    = need_read ? (3 + rd_dly + ack_dly) : (2 + ack_dly);
    obs_value  = '0;
    obs_strobe = '0;

    @(negedge clock);
    n_cmp++;
    if (bus.store_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_before_accept: got %b want 1", bus.store_ready);
    end
    bus.store_valid       = 1'b1;
    bus.funct3            = f3;
    bus.rs1_value         = rs1;
    bus.immediate12_store = imm;
    bus.rs2_value         = rs2;
    @(posedge clock);
    #1;
    bus.store_valid = 1'b0;
    bus.rs2_value   = $urandom();

    if (fault) begin
      n_cmp++;
      if ({bus.store_fault, bus.memory_read_request, bus.memory_write_request, bus.store_ready}
          !== 4'b1001) begin
        n_err++;
        $display("FAIL fault_pulse f3=%0d ea=%h: got flt/rd/wr/rdy=%b%b%b%b want 1001", f3, ea,
                 bus.store_fault, bus.memory_read_request, bus.memory_write_request,
                 bus.store_ready);
      end
      @(posedge clock);
      #1;
      n_cmp++;
      if ({bus.store_fault, bus.memory_read_request, bus.memory_write_request, bus.store_done}
          !== 4'b0000) begin
        n_err++;
        $display("FAIL fault_clear: got flt/rd/wr/done=%b%b%b%b want 0000", bus.store_fault,
                 bus.memory_read_request, bus.memory_write_request, bus.store_done);
      end
      return;
    end

    cyc = 0; rd_wait = 0; ack_wait = 0;
    saw_read = 1'b0; saw_write = 1'b0; done = 1'b0;
    while (!done && cyc < 64) begin
      if (bus.store_done) begin
        done = 1'b1;
      end else begin
        if (bus.memory_read_request) begin
          n_cmp++;
          if (bus.memory_read_address !== exp_addr) begin
            n_err++;
            $display("FAIL read_address: got %h want %h", bus.memory_read_address, exp_addr);
          end
          saw_read = 1'b1;
          if (rd_wait == rd_dly) begin
            bus.memory_read_valid = 1'b1;
            bus.memory_read_value = rword;
          end
          rd_wait++;
        end
        if (bus.memory_write_request) begin
          n_cmp++;
          if ({bus.memory_write_address, bus.memory_write_value, bus.memory_write_strobe}
              !== {exp_addr, exp_value, exp_strobe}) begin
            n_err++;
            $display("FAIL write_beat: got addr=%h val=%h strb=%h want addr=%h val=%h strb=%h",
                     bus.memory_write_address, bus.memory_write_value, bus.memory_write_strobe,
                     exp_addr, exp_value, exp_strobe);
          end
          if (!saw_write) begin
            obs_value  = bus.memory_write_value;
            obs_strobe = bus.memory_write_strobe;
          end
          saw_write = 1'b1;
          if (ack_wait == ack_dly) bus.memory_write_ack = 1'b1;
          ack_wait++;
        end
        @(posedge clock);
        #1;
        bus.memory_read_valid = 1'b0;
        bus.memory_write_ack  = 1'b0;
        bus.memory_read_value = $urandom();
        cyc++;
      end
    end

    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL done_timeout: no store_done within %0d cycles", cyc);
    end else if (cyc + 1 != exp_lat) begin
      n_err++;
      $display("FAIL latency: got %0d cycles want %0d", cyc + 1, exp_lat);
    end
    n_cmp++;
    if ({saw_read, saw_write, bus.store_ready} !== {need_read, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL phases: got read/write/ready=%b%b%b want %b11", saw_read, saw_write,
               bus.store_ready, need_read);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if ({bus.memory_read_request, bus.memory_write_request, bus.store_done, bus.store_fault,
         bus.store_ready} !== 5'b00001) begin
      n_err++;
      $display("FAIL reset_ctrl: got rd/wr/done/flt/rdy=%b%b%b%b%b want 00001",
               bus.memory_read_request, bus.memory_write_request, bus.store_done,
               bus.store_fault, bus.store_ready);
    end
    n_cmp++;
    if ({bus.memory_read_address, bus.memory_write_address, bus.memory_write_value,
         bus.memory_write_strobe} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got ra=%h wa=%h wv=%h ws=%h want all 0",
               bus.memory_read_address, bus.memory_write_address, bus.memory_write_value,
               bus.memory_write_strobe);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] v;
    logic [3:0]  s;
    run_store(3'd0, 32'h1000, 12'h003, 32'h0000_00AB, 32'h1122_3344, 0, 0, v, s);
`ifdef STORE_BYTE_ENABLE_EN
    n_cmp++;
    if ({v, s} !== {32'hAB00_0000, 4'h8}) begin
      n_err++;
      $display("FAIL sb_byte_enable: got %h/%h want ab000000/8", v, s);
    end
`else
    n_cmp++;
    if ({v, s} !== {32'hAB22_3344, 4'hF}) begin
      n_err++;
      $display("FAIL sb_offset3: got %h/%h want ab223344/f", v, s);
    end
`endif
    run_store(3'd1, 32'h1002, 12'h000, 32'h0000_BEEF, 32'h1122_3344, 1, 2, v, s);
`ifdef STORE_BYTE_ENABLE_EN
    n_cmp++;
    if ({v, s} !== {32'hBEEF_0000, 4'hC}) begin
      n_err++;
      $display("FAIL sh_byte_enable: got %h/%h want beef0000/c", v, s);
    end
`else
    n_cmp++;
    if ({v, s} !== {32'hBEEF_3344, 4'hF}) begin
      n_err++;
      $display("FAIL sh_offset2: got %h/%h want beef3344/f", v, s);
    end
`endif
    run_store(3'd2, 32'h1004, 12'hFFC, 32'hDEAD_BEEF, 32'h0, 0, 0, v, s);
    n_cmp++;
    if ({v, s} !== {32'hDEAD_BEEF, 4'hF}) begin
      n_err++;
      $display("FAIL sw_negative: got %h/%h want deadbeef/f", v, s);
    end
  endtask

  task automatic test_faults();
    logic [31:0] v;
    logic [3:0]  s;
    run_store(3'd1, 32'h1001, 12'h000, 32'h1234, 32'h0, 0, 0, v, s);
    run_store(3'd3, 32'h1000, 12'h000, 32'h1234, 32'h0, 0, 0, v, s);
    run_store(3'd5, 32'h1000, 12'h000, 32'h1234, 32'h0, 0, 0, v, s);
    run_store(3'd2, 32'h0FFF, 12'h003, 32'h1234, 32'h0, 0, 0, v, s);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [3:0]  s;
    run_store(3'd2, 32'h2000, 12'h010, 32'hCAFE_F00D, 32'h0, 0, 0, v, s);
    run_store(3'd0, 32'h2001, 12'h000, 32'h0000_005A, 32'hFFFF_FFFF, 0, 0, v, s);
    run_store(3'd2, 32'hFFFF_FFFC, 12'h008, 32'h0BAD_CAFE, 32'h0, 0, 1, v, s);
  endtask

  task automatic test_spurious_handshakes();
    @(negedge clock);
    bus.memory_read_valid = 1'b1;
    bus.memory_write_ack  = 1'b1;
    @(posedge clock);
    #1;
    bus.memory_read_valid = 1'b0;
    bus.memory_write_ack  = 1'b0;
    n_cmp++;
    if ({bus.memory_read_request, bus.memory_write_request, bus.store_done, bus.store_ready}
        !== 4'b0001) begin
      n_err++;
      $display("FAIL spurious_idle: got rd/wr/done/rdy=%b%b%b%b want 0001",
               bus.memory_read_request, bus.memory_write_request, bus.store_done,
               bus.store_ready);
    end
  endtask

  task automatic test_reset_mid_flight();
    @(negedge clock);
    bus.store_valid       = 1'b1;
    bus.funct3            = 3'd0;
    bus.rs1_value         = 32'h1000;
    bus.immediate12_store = 12'h003;
    bus.rs2_value         = 32'hAB;
    @(posedge clock);
    #1;
    bus.store_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if ({bus.memory_read_request, bus.memory_write_request} !== {!ByteEn, ByteEn}) begin
      n_err++;
      $display("FAIL req_before_reset: got rd/wr=%b%b want %b%b", bus.memory_read_request,
               bus.memory_write_request, !ByteEn, ByteEn);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.memory_read_request, bus.memory_write_request, bus.store_done, bus.store_ready}
        !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_mid_ctrl: got rd/wr/done/rdy=%b%b%b%b want 0001",
               bus.memory_read_request, bus.memory_write_request, bus.store_done,
               bus.store_ready);
    end
    n_cmp++;
    if ({bus.memory_read_address, bus.memory_write_address, bus.memory_write_value,
         bus.memory_write_strobe} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_data: got ra=%h wa=%h wv=%h ws=%h want all 0",
               bus.memory_read_address, bus.memory_write_address, bus.memory_write_value,
               bus.memory_write_strobe);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n               = 1'b1;
    bus.memory_read_valid = 1'b1;
    bus.memory_write_ack  = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    bus.memory_read_valid = 1'b0;
    bus.memory_write_ack  = 1'b0;
    n_cmp++;
    if ({bus.memory_read_request, bus.memory_write_request, bus.store_done, bus.store_ready}
        !== 4'b0001) begin
      n_err++;
      $display("FAIL after_reset_release: got rd/wr/done/rdy=%b%b%b%b want 0001",
               bus.memory_read_request, bus.memory_write_request, bus.store_done,
               bus.store_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [3:0]  s;
    logic [2:0]  f3;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      else                           f3 = 3'($urandom_range(0, 7));
      run_store(f3, $urandom(), 12'($urandom()), $urandom(), $urandom(),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), v, s);
    end
  endtask

  initial begin
    bus.store_valid       = 1'b0;
    bus.funct3            = 3'd0;
    bus.rs1_value         = '0;
    bus.rs2_value         = '0;
    bus.immediate12_store = '0;
    bus.memory_read_valid = 1'b0;
    bus.memory_read_value = '0;
    bus.memory_write_ack  = 1'b0;

    test_reset();
    test_directed();
    test_faults();
    test_back_to_back();
    test_spurious_handshakes();
    test_reset_mid_flight();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
